// File: rtl/keypad_scan.sv
// Matrix keypad scanner: active-low column strobes, synchronised and debounced
// row sensing, one {held, code} event per press over a valid/ack handshake.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
  parameter int N_COLS         = 4,
  parameter int N_ROWS         = 4,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int REPEAT_TICKS   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [N_ROWS-1:0] row_n,
  output logic [N_COLS-1:0] col_sel_n,
  output logic [4:0]        key_out,
  output logic              key_valid,
  input  logic              key_ack
);

  localparam int CW = $clog2(N_COLS);
  localparam int RW = $clog2(N_ROWS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     col, col_d, cand_col, cand_col_d;
  logic [RW-1:0]     cand_row, cand_row_d, hit_row;
  logic [3:0]        cnt, cnt_d, rcnt, rcnt_d;
  logic [3:0]        cand_code, key_code;
  logic [N_ROWS-1:0] rows_meta, rows_s;
  logic              hit, cand_low, key_event;

`ifdef KEYPAD_REPEAT_EN
  localparam int PW = $clog2(REPEAT_TICKS + 1);
  logic [PW-1:0] rpt, rpt_d;
`endif

  function automatic logic [CW-1:0] col_inc(input logic [CW-1:0] c);
    return (c == CW'(N_COLS - 1)) ? '0 : c + CW'(1);
  endfunction

  // Row lines are asynchronous to clk, so nothing downstream sees them raw.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_meta <= '1;
      rows_s    <= '1;
    end else begin
      rows_meta <= row_n;
      rows_s    <= rows_meta;
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_row = '0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (!rows_s[i]) begin
        hit     = 1'b1;
        hit_row = RW'(i);
      end
    end
  end

  assign cand_low  = ~rows_s[cand_row];
  assign cand_code = 4'(int'(cand_row) * N_COLS + int'(cand_col));

  // NOTE: every output of this block gets a default first, otherwise paths
  // that do not assign it would infer a latch.
  always_comb begin
    state_d    = state;
    col_d      = col;
    cand_row_d = cand_row;
    cand_col_d = cand_col;
    cnt_d      = cnt;
    rcnt_d     = rcnt;
    key_event  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d      = rpt;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (hit) begin
            cand_row_d = hit_row;
            cand_col_d = col;
            cnt_d      = '0;
            state_d    = DEBOUNCE;
          end else begin
            col_d = col_inc(col);
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            cnt_d = cnt + 4'd1;
            if (cnt == 4'(DEBOUNCE_TICKS - 1)) begin
              state_d   = HELD;
              rcnt_d    = '0;
              key_event = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rpt_d     = '0;
`endif
            end
          end else begin
            state_d = SCAN;
            col_d   = col_inc(col);
          end
        end
        HELD: begin
`ifdef KEYPAD_REPEAT_EN
          // Repeat pacing pauses once a release starts to be seen.
          if (rcnt == 4'd0) begin
            if (rpt == PW'(REPEAT_TICKS - 1)) begin
              rpt_d     = '0;
              key_event = 1'b1;
            end else begin
              rpt_d = rpt + PW'(1);
            end
          end
`endif
          if (cand_low) begin
            rcnt_d = '0;
          end else if (rcnt == 4'(DEBOUNCE_TICKS - 1)) begin
            rcnt_d  = '0;
            state_d = SCAN;
            col_d   = col_inc(col);
          end else begin
            rcnt_d = rcnt + 4'd1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col       <= '0;
      col_sel_n <= ~N_COLS'(1);
      cand_row  <= '0;
      cand_col  <= '0;
      cnt       <= '0;
      rcnt      <= '0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      col_sel_n <= ~(N_COLS'(1) << col_d);
      cand_row  <= cand_row_d;
      cand_col  <= cand_col_d;
      cnt       <= cnt_d;
      rcnt      <= rcnt_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) rpt <= '0;
    else     rpt <= rpt_d;
  end
`endif

  // A pending unacknowledged event is never overwritten; an ack in the same
  // cycle frees the slot for the new event.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
    end else if (key_event && (!key_valid || key_ack)) begin
      key_valid <= 1'b1;
      key_code  <= cand_code;
    end else if (key_ack) begin
      key_valid <= 1'b0;
    end
  end

  assign key_out = {state == HELD, key_code};

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad matrix model drives the rows,
// directed tables and sequences check timing, random presses check events.
module tb_keypad_scan;

  logic       clk, rst, tick, key_ack;
  logic [3:0] row_n, col_sel_n;
  logic [4:0] key_out;
  logic       key_valid;

  logic [15:0] pressed;   // bit r*4+c = key at row r, column c is down
  bit          auto_ack;
  logic [3:0]  got[$];
  int          checks, errors;

`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD70_EVENTS = 3;
`else
  localparam int HOLD70_EVENTS = 1;
`endif

  keypad_scan dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .row_n    (row_n),
    .col_sel_n(col_sel_n),
    .key_out  (key_out),
    .key_valid(key_valid),
    .key_ack  (key_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed switch shorts its row to the strobed column.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_sel_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Three idle cycles, one tick cycle; returns one clk after the tick edge.
  task automatic tick_once(input bit ack_with);
    repeat (3) @(negedge clk);
    tick = 1'b1;
    key_ack = ack_with;
    @(negedge clk);
    tick = 1'b0;
    key_ack = 1'b0;
    if (auto_ack && key_valid) begin
      got.push_back(key_out[3:0]);
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_rst_and_check(input string name);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({name, "_col"}, col_sel_n, 4'b1110);
    check({name, "_out"}, key_out, 5'h00);
    check({name, "_valid"}, key_valid, 1'b0);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  // Code 5 pending unacked, release, then press code 6 to confirmation.
  task automatic press5_then6(input bit ack_last);
    do_reset();
    pressed = 16'h0020;
    repeat (5) tick_once(1'b0);
    check("p5_valid", key_valid, 1'b1);
    check("p5_code", key_out, 5'h15);
    pressed = '0;
    repeat (3) tick_once(1'b0);
    check("p5_released", key_out, 5'h05);
    pressed = 16'h0040;
    repeat (3) tick_once(1'b0);
    tick_once(ack_last);
  endtask

  typedef struct {
    logic [15:0] keys;
    int          hold;
    bit          exp_ev;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst = 1'b1; tick = 1'b0; key_ack = 1'b0; pressed = '0; auto_ack = 1'b0;
    checks = 0; errors = 0;
    vecs[0] = '{16'h0200, 10, 1'b1, 4'd9};
    vecs[1] = '{16'h0008,  2, 1'b0, 4'd0};
    vecs[2] = '{16'h1010, 10, 1'b1, 4'd4};
    vecs[3] = '{16'h8000, 12, 1'b1, 4'd15};
    vecs[4] = '{16'h0001,  9, 1'b1, 4'd0};
    vecs[5] = '{16'h0404, 11, 1'b1, 4'd2};
    repeat (2) @(negedge clk);
    do_reset();

    check("rst_col", col_sel_n, 4'b1110);
    check("rst_out", key_out, 5'h00);
    check("rst_valid", key_valid, 1'b0);

    // Idle scan walks the columns and wraps.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((i + 1) % 4));
      tick_once(1'b0);
      check("scan_col", col_sel_n, exp_col);
      check("scan_valid", key_valid, 1'b0);
      check("scan_out", key_out, 5'h00);
    end

    // Exact press latency and handshake, key at row 2 / col 1.
    do_reset();
    pressed = 16'h0200;
    repeat (4) tick_once(1'b0);
    check("lat_early", key_valid, 1'b0);
    tick_once(1'b0);
    check("lat_valid", key_valid, 1'b1);
    check("lat_out", key_out, 5'h19);
    ack_pulse();
    check("ack_clear", key_valid, 1'b0);
    check("ack_out", key_out, 5'h19);
    pressed = '0;
    repeat (2) tick_once(1'b0);
    check("rel_still_held", key_out, 5'h19);
    tick_once(1'b0);
    check("rel_held", key_out, 5'h09);
    check("rel_col", col_sel_n, 4'b1011);

    // Bounce: row 0 low on col 3 for only two samples.
    do_reset();
    pressed = 16'h0008;
    repeat (5) tick_once(1'b0);
    pressed = '0;
    tick_once(1'b0);
    check("bounce_col", col_sel_n, 4'b1110);
    repeat (4) tick_once(1'b0);
    check("bounce_valid", key_valid, 1'b0);

    // Two rows low on col 0: lowest row wins.
    do_reset();
    pressed = 16'h1010;
    repeat (4) tick_once(1'b0);
    check("multi_valid", key_valid, 1'b1);
    check("multi_out", key_out, 5'h14);
    ack_pulse();
    pressed = '0;
    repeat (3) tick_once(1'b0);
    check("multi_rel", key_out, 5'h04);
    check("multi_col", col_sel_n, 4'b1101);

    // Drop while pending, then same-cycle ack lets the new event through.
    press5_then6(1'b0);
    check("drop_valid", key_valid, 1'b1);
    check("drop_out", key_out, 5'h15);
    press5_then6(1'b1);
    check("ackwin_valid", key_valid, 1'b1);
    check("ackwin_out", key_out, 5'h16);
    ack_pulse();
    check("ackwin_clear", key_valid, 1'b0);
    pressed = '0;

    // Reset mid-debounce and while held.
    do_reset();
    pressed = 16'h0200;
    repeat (2) tick_once(1'b0);
    pulse_rst_and_check("rst_deb");
    repeat (5) tick_once(1'b0);
    check("rst_held_pre", key_out, 5'h19);
    pulse_rst_and_check("rst_held");
    pressed = '0;

    // Long hold: one event per press, plus repeats when enabled.
    do_reset();
    auto_ack = 1'b1;
    got.delete();
    pressed = 16'h0200;
    repeat (75) tick_once(1'b0);
    pressed = '0;
    repeat (4) tick_once(1'b0);
    check("hold70_events", got.size(), HOLD70_EVENTS);
    foreach (got[i]) check("hold70_code", got[i], 4'd9);
    check("hold70_rel", key_out[4], 1'b0);

    // Table-driven presses from whatever column the scan is on.
    for (int v = 0; v < 6; v++) begin
      got.delete();
      pressed = vecs[v].keys;
      repeat (vecs[v].hold) tick_once(1'b0);
      pressed = '0;
      repeat (6) tick_once(1'b0);
      check("vec_count", got.size(), vecs[v].exp_ev);
      if (got.size() > 0) check("vec_code", got[0], vecs[v].exp_code);
      check("vec_held", key_out[4], 1'b0);
    end

    // Random single-key presses: long ones yield their index, glitches nothing.
    for (int it = 0; it < 40; it++) begin
      int  k, hold;
      bit  long_press;
      k = $urandom_range(15, 0);
      long_press = 1'($urandom_range(1, 0));
      hold = long_press ? $urandom_range(20, 9) : $urandom_range(2, 1);
      got.delete();
      pressed = '0;
      pressed[k] = 1'b1;
      repeat (hold) tick_once(1'b0);
      pressed = '0;
      repeat ($urandom_range(8, 5)) tick_once(1'b0);
      check("rnd_count", got.size(), long_press);
      if (got.size() > 0) check("rnd_code", got[0], k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Matrix keypad scanner; the input-side counterpart of the multiplexed display driver.
- Strobes keypad columns active-low, one at a time, paced by the shared `tick` strobe.
- Reads the active-low row lines, debounces press and release, and delivers one hex key code per press through a valid/ack handshake.
- Output code format matches the display path (bit 4 = flag, bits 3:0 = hex) so a key can be routed straight to a display digit.

Parameters:
- N_COLS, 4, number of column strobes (2..4)
- N_ROWS, 4, number of row inputs (2..4); N_ROWS*N_COLS <= 16
- DEBOUNCE_TICKS, 3, consecutive confirming ticks required for press and for release (1..15)
- REPEAT_TICKS, 32, ticks between auto-repeat events (used only with KEYPAD_REPEAT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  one-cycle scan-rate strobe
- row_n  in  N_ROWS  row lines, active-low, asynchronous (pulled up externally)
- col_sel_n  out  N_COLS  column strobe, exactly one bit low
- key_out  out  5  {key_held, key_code[3:0]}
- key_valid  out  1  new key event pending
- key_ack  in  1  consumer accepts the pending event (1-cycle pulse)

Behaviour:
- Clock and reset:
  - Single clock domain, clk rising edge.
  - rst is synchronous, active-high, and overrides everything, including mid-debounce and while HELD.
- Reset values:
  - state=SCAN, col index=0, col_sel_n = all ones except bit0 = 0.
  - key_code=0, key_held=0, key_valid=0, all counters 0, sync flops all ones.
- Input synchronisation:
  - row_n passes through a 2-flop synchroniser (rows_s).
  - Only rows_s is used.
- Sampling:
  - All FSM evaluation happens only on cycles with tick=1, using rows_s at that cycle.
  - Requirement on the integrator: tick period >= 4 clk, which gives column settle plus synchroniser delay.
- Row hit:
  - Any row bit of rows_s = 0 counts as a hit.
  - If several rows are low, the lowest row index wins.
- Key code: code = row*N_COLS + col, 4 bits, zero-extended.
- FSM:
  - SCAN:
    - On tick with no hit: col advances (N_COLS-1 wraps to 0) and col_sel_n updates the next cycle.
    - On tick with a hit: latch cand_row and cand_col, set cnt=0, go to DEBOUNCE. The column is not advanced.
  - DEBOUNCE:
    - On tick with the same row low on the same column: cnt++.
    - When cnt reaches DEBOUNCE_TICKS: go to HELD, key_held=1, and raise a key event.
    - On tick with cand_row high: go to SCAN and advance the column (bounce rejected, no event).
  - HELD:
    - On tick with cand_row high: rcnt++. On tick with cand_row low: rcnt=0.
    - When rcnt reaches DEBOUNCE_TICKS: key_held=0, go to SCAN, advance the column.
    - Other keys pressed while HELD are ignored.
- Key event:
  - key_code <= code and key_valid <= 1, registered, in the cycle after the confirming tick.
  - Latency from the first sampling tick to key_valid = DEBOUNCE_TICKS ticks + 1 clk.
- Handshake:
  - key_valid stays high until key_ack is sampled high. It clears the next cycle.
  - key_ack while key_valid=0 is ignored.
  - A new event while key_valid=1 and no ack in the same cycle: event dropped, key_code unchanged.
  - A new event in the same cycle as key_ack: the new event wins. key_valid stays 1 and key_code takes the new code.
- key_out[4] = key_held, a level, independent of the handshake.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts ticks.
  - After REPEAT_TICKS ticks it raises a new key event with the same code, then restarts the count.
  - The repeat counter resets on entry to HELD.
  - The repeat counter is frozen while release debouncing is in progress (rcnt > 0).
  - Repeat events follow the same handshake and drop rules as press events.
- Undefined: exactly one event per press; REPEAT_TICKS is unused and no repeat counter is synthesised.

Test Plan:
- Reset, then 8 ticks with no keys pressed -> col_sel_n sequence 1110,1101,1011,0111,1110,...; key_valid=0, key_out=5'h00.
- Row 2 held low while col 1 is strobed, steady for 4 ticks -> key_valid rises 1 clk after the 4th sampling tick, key_out=5'h19 (held, code 9); key_ack pulse -> key_valid=0 next cycle, key_out stays 5'h19.
- Row 0 low on col 3 for only 2 ticks, then high -> no key_valid; scanning resumes at col 0.
- Rows 1 and 3 low on col 0 together -> code 4 (lowest row wins); key released for 3 ticks -> key_held=0 and scan resumes.
- Press code 5 with no ack, release, then press code 6 -> key_valid stays 1 and key_code stays 5. Repeat with key_ack in the same cycle as the code-6 event -> key_valid stays 1, key_code=6.
- rst asserted while in DEBOUNCE and again while HELD -> next cycle all outputs at reset values; with KEYPAD_REPEAT_EN and REPEAT_TICKS=32, holding code 9 for 70 ticks after confirmation -> 3 events total, each acked.
